// File: rtl/alu_seq_loader.sv
// ---------------------------------------------------------------------------
// alu_seq_loader
//
// Loads two W-bit operands and an opcode from a narrow switch bus, one
// SWW-bit beat per load strobe (least-significant chunk first). It then runs
// a single ALU operation and holds the registered result and flags until the
// next execution or abort.
//
// Parameters
//   W    ALU data width (a multiple of SWW, at least 8)
//   SWW  switch-bus width; NB = W/SWW beats per operand
//   WOP  opcode width (at most SWW)
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst       in   asynchronous active-low reset
//   sw        in   switch bus, sampled only on an accepted load beat
//   load      in   one-cycle beat strobe (already debounced/edge-detected)
//   clr       in   synchronous sequence abort, has priority over load
//   y         out  registered ALU result
//   carry     out  ADD carry-out
//   borrow    out  SUB unsigned borrow (A < B)
//   overflow  out  ADD/SUB signed overflow
//   zero      out  y == 0
//   neg       out  y[W-1]
//   valid     out  y and flags hold a completed result
//   phase     out  current FSM state
//
// state   | meaning
// --------+-----------------------------------------------------------------
// LOAD_A  | collecting operand A beats, chunk index k
// LOAD_B  | collecting operand B beats, chunk index k
// LOAD_OP | waiting for the opcode beat
// EXEC    | one-cycle execute; load ignored, result registered on exit
// DONE    | result valid; a load here starts the next A (chunk 0)
// ---------------------------------------------------------------------------
module alu_seq_loader #(
    parameter int W   = 16,
    parameter int SWW = 8,
    parameter int WOP = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SWW-1:0] sw,
    input  logic           load,
    input  logic           clr,
    output logic [W-1:0]   y,
    output logic           carry,
    output logic           borrow,
    output logic           overflow,
    output logic           zero,
    output logic           neg,
    output logic           valid,
    output logic [2:0]     phase
);

    localparam int NB  = W / SWW;
    localparam int KW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int SHW = $clog2(W);

    localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

    localparam logic [WOP-1:0] OP_ADD = WOP'(6'b100000);
    localparam logic [WOP-1:0] OP_SUB = WOP'(6'b100010);
    localparam logic [WOP-1:0] OP_AND = WOP'(6'b100100);
    localparam logic [WOP-1:0] OP_OR  = WOP'(6'b100101);
    localparam logic [WOP-1:0] OP_XOR = WOP'(6'b100110);
    localparam logic [WOP-1:0] OP_NOR = WOP'(6'b100111);
    localparam logic [WOP-1:0] OP_SRL = WOP'(6'b000010);
    localparam logic [WOP-1:0] OP_SRA = WOP'(6'b000011);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t         state;
    logic [KW-1:0]  k;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [WOP-1:0] op_reg;

    logic [W:0]     sum;
    logic [W-1:0]   diff;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   alu_y;
    logic           alu_c;
    logic           alu_b;
    logic           alu_v;

    assign phase = state;

    // ALU works purely from the captured registers; its result is only
    // registered on the edge leaving EXEC.
    always_comb begin
        sum   = {1'b0, a_reg} + {1'b0, b_reg};
        diff  = a_reg - b_reg;
        shamt = b_reg[SHW-1:0];
        alu_y = '0;
        alu_c = 1'b0;
        alu_b = 1'b0;
        alu_v = 1'b0;
        case (op_reg)
            OP_ADD: begin
                alu_y = sum[W-1:0];
                alu_c = sum[W];
                alu_v = (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]);
            end
            OP_SUB: begin
                alu_y = diff;
                alu_b = (a_reg < b_reg);
                alu_v = (a_reg[W-1] ^ b_reg[W-1]) & (a_reg[W-1] ^ diff[W-1]);
            end
            OP_AND:  alu_y = a_reg & b_reg;
            OP_OR:   alu_y = a_reg | b_reg;
            OP_XOR:  alu_y = a_reg ^ b_reg;
            OP_NOR:  alu_y = ~(a_reg | b_reg);
            OP_SRL:  alu_y = a_reg >> shamt;
            OP_SRA:  alu_y = $unsigned($signed(a_reg) >>> shamt);
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOAD_A;
            k        <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            y        <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
            valid    <= 1'b0;
        end else if (clr) begin
            state    <= LOAD_A;
            k        <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            y        <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (load) begin
                        for (int i = 0; i < NB; i++) begin
                            if (k == KW'(i)) a_reg[i*SWW +: SWW] <= sw;
                        end
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= LOAD_B;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (load) begin
                        for (int i = 0; i < NB; i++) begin
                            if (k == KW'(i)) b_reg[i*SWW +: SWW] <= sw;
                        end
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= LOAD_OP;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                LOAD_OP: begin
                    if (load) begin
                        op_reg <= sw[WOP-1:0];
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    y        <= alu_y;
                    carry    <= alu_c;
                    borrow   <= alu_b;
                    overflow <= alu_v;
                    zero     <= (alu_y == '0);
                    neg      <= alu_y[W-1];
                    valid    <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    // The beat that leaves DONE is already chunk 0 of the
                    // next A; y and flags stay put until the next EXEC.
                    if (load) begin
                        valid              <= 1'b0;
                        a_reg[SWW-1:0]     <= sw;
                        if (NB == 1) begin
                            k     <= '0;
                            state <= LOAD_B;
                        end else begin
                            k     <= KW'(1);
                            state <= LOAD_A;
                        end
                    end
                end
                default: begin
                    state <= LOAD_A;
                    k     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_loader.sv
module tb_alu_seq_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  sw;
    logic        load;
    logic        clr;
    logic [15:0] y;
    logic        carry, borrow, overflow, zero, neg, valid;
    logic [2:0]  phase;

    int total = 0;
    int bad   = 0;

    alu_seq_loader #(.W(16), .SWW(8), .WOP(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .load     (load),
        .clr      (clr),
        .y        (y),
        .carry    (carry),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero),
        .neg      (neg),
        .valid    (valid),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted beat: drive just after an edge, consumed on the next edge.
    task automatic beat(input logic [7:0] v);
        sw   = v;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
        beat(a[7:0]);
        beat(a[15:8]);
        beat(b[7:0]);
        beat(b[15:8]);
        beat(op);
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [15:0] ey, input logic ec,
                             input logic eb, input logic ev, input logic ez, input logic en);
        check({tag, ".y"},        32'(y),        32'(ey));
        check({tag, ".carry"},    32'(carry),    32'(ec));
        check({tag, ".borrow"},   32'(borrow),   32'(eb));
        check({tag, ".overflow"}, 32'(overflow), 32'(ev));
        check({tag, ".zero"},     32'(zero),     32'(ez));
        check({tag, ".neg"},      32'(neg),      32'(en));
        check({tag, ".valid"},    32'(valid),    32'd1);
        check({tag, ".phase"},    32'(phase),    32'd4);
    endtask

    initial begin
        rst  = 1'b1;
        clr  = 1'b0;
        load = 1'b0;
        sw   = 8'h00;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.y",     32'(y),     32'h0);
        check("rst.flags", 32'({carry, borrow, overflow, zero, neg}), 32'h0);
        check("rst.valid", 32'(valid), 32'h0);
        check("rst.phase", 32'(phase), 32'h0);
        rst = 1'b1;

        // ADD FFFF + 0001 wraps to zero with carry; first beat right after reset
        beat(8'hFF);
        check("add.k1_phase", 32'(phase), 32'd0);
        beat(8'hFF);
        check("add.b_phase", 32'(phase), 32'd1);
        beat(8'h01);
        beat(8'h00);
        check("add.op_phase", 32'(phase), 32'd2);
        beat(8'h20);
        check("add.exec_phase", 32'(phase), 32'd3);
        check("add.exec_valid", 32'(valid), 32'd0);
        @(posedge clk);
        #1;
        check_res("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("hold.y", 32'(y), 32'h0);
        check("hold.valid", 32'(valid), 32'd1);

        run_op(16'h8000, 16'h0001, 8'h22);
        check_res("sub_ovf", 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        run_op(16'h8000, 16'h000F, 8'h03);
        check_res("sra", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        run_op(16'h8000, 16'h000F, 8'h02);
        check_res("srl", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // load in DONE starts a new A and keeps the old result visible
        beat(8'h12);
        check("done_ld.valid", 32'(valid), 32'd0);
        check("done_ld.phase", 32'(phase), 32'd0);
        check("done_ld.a_lo",  32'(dut.a_reg[7:0]), 32'h12);
        check("done_ld.y",     32'(y), 32'h0001);
        beat(8'h00);
        check("done_ld.b_phase", 32'(phase), 32'd1);
        beat(8'hFF);
        beat(8'h00);
        beat(8'h26);
        @(posedge clk);
        #1;
        check_res("xor", 16'h00ED, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op(16'h7FFF, 16'h0001, 8'h20);
        check_res("add_ovf", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        run_op(16'h0001, 16'h0002, 8'h22);
        check_res("sub_borrow", 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // upper switch bits above the opcode field are ignored (E7 -> NOR)
        run_op(16'hF0F0, 16'h0FF0, 8'hE7);
        check_res("nor", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op(16'hF0F0, 16'h0FF0, 8'h24);
        check_res("and", 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op(16'h1234, 16'h5678, 8'h3F);
        check_res("unknown", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        run_op(16'hF0F0, 16'h0FF0, 8'h25);
        check_res("or", 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // clr after A beat 0, with load asserted at the same edge
        beat(8'h55);
        clr  = 1'b1;
        load = 1'b1;
        sw   = 8'h77;
        @(posedge clk);
        #1;
        clr  = 1'b0;
        load = 1'b0;
        check("clr.phase", 32'(phase), 32'd0);
        check("clr.k",     32'(dut.k), 32'd0);
        check("clr.a",     32'(dut.a_reg), 32'h0);
        check("clr.y",     32'(y), 32'h0);
        check("clr.flags", 32'({carry, borrow, overflow, zero, neg}), 32'h0);
        check("clr.valid", 32'(valid), 32'd0);

        // load held high through EXEC must not disturb A, B or op
        beat(8'h03);
        beat(8'h00);
        beat(8'h04);
        beat(8'h00);
        sw   = 8'h20;
        load = 1'b1;
        @(posedge clk);
        #1;
        check("exec_ld.phase3", 32'(phase), 32'd3);
        sw = 8'hAA;
        @(posedge clk);
        #1;
        load = 1'b0;
        check("exec_ld.a",  32'(dut.a_reg), 32'h0003);
        check("exec_ld.b",  32'(dut.b_reg), 32'h0004);
        check("exec_ld.op", 32'(dut.op_reg), 32'h20);
        check_res("exec_ld", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // async reset in LOAD_B mid-operand, then a full fresh sequence
        beat(8'h34);
        beat(8'h12);
        beat(8'h56);
        check("rst_mid.pre_phase", 32'(phase), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid.y",     32'(y), 32'h0);
        check("rst_mid.flags", 32'({carry, borrow, overflow, zero, neg}), 32'h0);
        check("rst_mid.valid", 32'(valid), 32'd0);
        check("rst_mid.phase", 32'(phase), 32'd0);
        check("rst_mid.k",     32'(dut.k), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_op(16'h1234, 16'h0F0F, 8'h22);
        check_res("after_rst", 16'h0325, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
